// File: rtl/cordic_pkg.sv
// Shared CORDIC types and width helpers for the linear-mode divider and multiplier.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    CORR = 2'd2,
    DONE = 2'd3
  } cordic_div_state_t;

  // y holds a<<WIDTH minus b*z with headroom for the largest first rotation.
  function automatic int y_width(input int w);
    return 3 * w + 2;
  endfunction

  function automatic int z_width(input int w);
    return 2 * w + 2;
  endfunction

  function automatic int iter_count(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/cordic_div_if.sv
// Operand/result handshake bundle for cordic_div; remainder_o exists only with CORDIC_DIV_REM_EN.
interface cordic_div_if #(
  parameter int WIDTH = 8
);

  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [WIDTH-1:0]       a_i;
  logic [WIDTH-1:0]       b_i;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [2*WIDTH-1:0]     quotient_o;
  logic                   div0_o;
`ifdef CORDIC_DIV_REM_EN
  logic [WIDTH-1:0]       remainder_o;
`endif

  modport slave (
    input  in_valid_i, a_i, b_i, out_ready_i,
    output in_ready_o, out_valid_o, quotient_o, div0_o
`ifdef CORDIC_DIV_REM_EN
    , output remainder_o
`endif
  );

  modport master (
    output in_valid_i, a_i, b_i, out_ready_i,
    input  in_ready_o, out_valid_o, quotient_o, div0_o
`ifdef CORDIC_DIV_REM_EN
    , input remainder_o
`endif
  );

endinterface

// File: rtl/cordic_lin_stage.sv
// One combinational linear-mode CORDIC micro-rotation (vectoring or rotation), no state.
module cordic_lin_stage #(
  parameter int YW = 26,
  parameter int ZW = 18,
  parameter int SW = 4
) (
  input  logic signed [YW-1:0] x,
  input  logic signed [YW-1:0] y,
  input  logic signed [ZW-1:0] z,
  input  logic        [SW-1:0] shift,
  input  logic                 rot_mode,
  output logic signed [YW-1:0] y_nxt,
  output logic signed [ZW-1:0] z_nxt
);

  logic                 add_x;
  logic signed [YW-1:0] x_sh;
  logic signed [ZW-1:0] unit;
  logic signed [ZW-1:0] unit_sh;

  // Vectoring steers y toward zero; rotation steers z toward zero.
  assign add_x   = rot_mode ? ~z[ZW-1] : y[YW-1];
  assign x_sh    = x <<< shift;
  assign unit    = {{(ZW-1){1'b0}}, 1'b1};
  assign unit_sh = unit <<< shift;

  always_comb begin
    y_nxt = y;
    z_nxt = z;
    if (add_x) begin
      y_nxt = y + x_sh;
      z_nxt = z - unit_sh;
    end else begin
      y_nxt = y - x_sh;
      z_nxt = z + unit_sh;
    end
  end

endmodule

// File: rtl/cordic_div.sv
// Iterative CORDIC divider, quotient Q(W.W) truncated; 2*WIDTH+1 cycles (1 on b=0), result held until out_ready_i.
// Optional remainder_o output with CORDIC_DIV_REM_EN; one operation in flight, accepts only when idle.
module cordic_div
  import cordic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic        clk_i,
  input  logic        aresetn_i,
  cordic_div_if.slave bus
);

  localparam int YW = y_width(WIDTH);
  localparam int ZW = z_width(WIDTH);
  localparam int N  = iter_count(WIDTH);
  localparam int SW = $clog2(N);
  localparam int QW = 2 * WIDTH;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_ITER = ITER;
  localparam logic [1:0] ST_CORR = CORR;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]           state;
  logic [WIDTH-1:0]     x_q;
  logic signed [YW-1:0] y_q;
  logic signed [ZW-1:0] z_q;
  logic [SW-1:0]        k_q;
  logic                 zero_div_q;

  logic signed [YW-1:0] x_ext;
  logic signed [YW-1:0] y_rot;
  logic signed [ZW-1:0] z_rot;
  logic [SW-1:0]        shift;
  logic                 y_neg;
  logic signed [ZW-1:0] z_fin;
  logic signed [YW-1:0] y_fin;

  assign x_ext = $signed({{(YW-WIDTH){1'b0}}, x_q});
  assign shift = SW'(N - 1) - k_q;
  assign y_neg = y_q[YW-1];

  cordic_lin_stage #(
    .YW(YW),
    .ZW(ZW),
    .SW(SW)
  ) u_stage (
    .x        (x_ext),
    .y        (y_q),
    .z        (z_q),
    .shift    (shift),
    .rot_mode (1'b0),
    .y_nxt    (y_rot),
    .z_nxt    (z_rot)
  );

  // Final non-restoring fix-up: a negative residue means z overshot by one.
  always_comb begin
    z_fin = z_q;
    y_fin = y_q;
    if (y_neg) begin
      z_fin = z_q - ZW'(1);
`ifdef CORDIC_DIV_REM_EN
      y_fin = y_q + x_ext;
`endif
    end
  end

  assign bus.in_ready_o  = (state == ST_IDLE);
  assign bus.out_valid_o = (state == ST_DONE);

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state          <= ST_IDLE;
      x_q            <= '0;
      y_q            <= '0;
      z_q            <= '0;
      k_q            <= '0;
      zero_div_q     <= 1'b0;
      bus.quotient_o <= '0;
      bus.div0_o     <= 1'b0;
`ifdef CORDIC_DIV_REM_EN
      bus.remainder_o <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid_i) begin
            x_q <= bus.b_i;
            y_q <= YW'({bus.a_i, {WIDTH{1'b0}}});
            z_q <= '0;
            k_q <= '0;
            if (bus.b_i == '0) begin
              // Divide-by-zero still spends the CORR cycle so its result lands one cycle after accept.
              zero_div_q     <= 1'b1;
              bus.quotient_o <= '1;
              bus.div0_o     <= 1'b1;
`ifdef CORDIC_DIV_REM_EN
              bus.remainder_o <= '0;
`endif
              state <= ST_CORR;
            end else begin
              zero_div_q <= 1'b0;
              state      <= ST_ITER;
            end
          end
        end
        ST_ITER: begin
          y_q <= y_rot;
          z_q <= z_rot;
          k_q <= k_q + 1'b1;
          if (k_q == SW'(N - 1)) begin
            state <= ST_CORR;
          end
        end
        ST_CORR: begin
          if (!zero_div_q) begin
            z_q            <= z_fin;
            y_q            <= y_fin;
            bus.quotient_o <= QW'(z_fin);
            bus.div0_o     <= 1'b0;
`ifdef CORDIC_DIV_REM_EN
            bus.remainder_o <= WIDTH'(y_fin);
`endif
          end
          state <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready_i) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_div.sv
// Directed-vector bench for cordic_div: quotient/div0/remainder values, latency, backpressure, mid-op reset.
module tb_cordic_div;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cordic_div_if #(.WIDTH(W)) bus ();

  cordic_div #(.WIDTH(W)) dut (
    .clk_i     (clk),
    .aresetn_i (rst_n),
    .bus       (bus)
  );

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] q;
    logic           d;
    logic [W-1:0]   r;
    int             lat;
  } vec_t;

  vec_t vecs[8];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Starts and ends #1 after a rising edge with the DUT idle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [2*W-1:0] q, output logic d,
                        output logic [W-1:0] r, output int lat);
    chk("in_ready_before_accept", 32'(bus.in_ready_o), 32'd1);
    bus.a_i        = a;
    bus.b_i        = b;
    bus.in_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    lat = 0;
    while (!bus.out_valid_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    q = bus.quotient_o;
    d = bus.div0_o;
`ifdef CORDIC_DIV_REM_EN
    r = bus.remainder_o;
`else
    r = '0;
`endif
  endtask

  task automatic take_result();
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
    chk("in_ready_after_take", 32'(bus.in_ready_o), 32'd1);
    chk("out_valid_after_take", 32'(bus.out_valid_o), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready_o), 32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid_o), 32'd0);
    chk({tag, "_quotient"}, 32'(bus.quotient_o), 32'd0);
    chk({tag, "_div0"}, 32'(bus.div0_o), 32'd0);
`ifdef CORDIC_DIV_REM_EN
    chk({tag, "_remainder"}, 32'(bus.remainder_o), 32'd0);
`endif
  endtask

  initial begin
    logic [2*W-1:0] q;
    logic           d;
    logic [W-1:0]   r;
    int             lat;

    vecs[0] = '{a: 8'd6,   b: 8'd3,   q: 16'h0200, d: 1'b0, r: 8'd0, lat: 17};
    vecs[1] = '{a: 8'd1,   b: 8'd3,   q: 16'h0055, d: 1'b0, r: 8'd1, lat: 17};
    vecs[2] = '{a: 8'd255, b: 8'd1,   q: 16'hFF00, d: 1'b0, r: 8'd0, lat: 17};
    vecs[3] = '{a: 8'd0,   b: 8'd200, q: 16'h0000, d: 1'b0, r: 8'd0, lat: 17};
    vecs[4] = '{a: 8'd7,   b: 8'd0,   q: 16'hFFFF, d: 1'b1, r: 8'd0, lat: 1};
    vecs[5] = '{a: 8'd200, b: 8'd7,   q: 16'h1C92, d: 1'b0, r: 8'd2, lat: 17};
    vecs[6] = '{a: 8'd255, b: 8'd255, q: 16'h0100, d: 1'b0, r: 8'd0, lat: 17};
    vecs[7] = '{a: 8'd1,   b: 8'd255, q: 16'h0001, d: 1'b0, r: 8'd1, lat: 17};

    bus.in_valid_i  = 1'b0;
    bus.a_i         = '0;
    bus.b_i         = '0;
    bus.out_ready_i = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, q, d, r, lat);
      chk($sformatf("quotient_%0d_%0d", vecs[i].a, vecs[i].b), 32'(q), 32'(vecs[i].q));
      chk($sformatf("div0_%0d_%0d", vecs[i].a, vecs[i].b), 32'(d), 32'(vecs[i].d));
      chk($sformatf("latency_%0d_%0d", vecs[i].a, vecs[i].b), 32'(lat), 32'(vecs[i].lat));
`ifdef CORDIC_DIV_REM_EN
      chk($sformatf("remainder_%0d_%0d", vecs[i].a, vecs[i].b), 32'(r), 32'(vecs[i].r));
`endif
      take_result();
    end

    // Backpressure: result held five cycles while new operands are offered and ignored.
    run_op(8'd200, 8'd7, q, d, r, lat);
    chk("stall_first_quotient", 32'(q), 32'h1C92);
    for (int i = 0; i < 5; i++) begin
      bus.a_i        = 8'(i + 1);
      bus.b_i        = 8'd1;
      bus.in_valid_i = 1'b1;
      @(posedge clk); #1;
      chk("stall_out_valid", 32'(bus.out_valid_o), 32'd1);
      chk("stall_in_ready", 32'(bus.in_ready_o), 32'd0);
      chk("stall_quotient", 32'(bus.quotient_o), 32'h1C92);
      chk("stall_div0", 32'(bus.div0_o), 32'd0);
    end
    bus.in_valid_i = 1'b0;
    take_result();
    chk("quotient_kept_after_take", 32'(bus.quotient_o), 32'h1C92);
    run_op(8'd1, 8'd3, q, d, r, lat);
    chk("after_stall_quotient", 32'(q), 32'h0055);
    chk("after_stall_latency", 32'(lat), 32'd17);
    take_result();

    // Reset asserted while iterating at k=5.
    bus.a_i        = 8'd6;
    bus.b_i        = 8'd3;
    bus.in_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("midop_busy_in_ready", 32'(bus.in_ready_o), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midop_reset");
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_in_ready", 32'(bus.in_ready_o), 32'd1);
    chk("post_reset_out_valid", 32'(bus.out_valid_o), 32'd0);
    run_op(8'd6, 8'd3, q, d, r, lat);
    chk("post_reset_quotient", 32'(q), 32'h0200);
    chk("post_reset_div0", 32'(d), 32'd0);
    chk("post_reset_latency", 32'(lat), 32'd17);
    take_result();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
